// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transmit/receive link
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} spi_tx_state_t;

    localparam int   SPI_WIDTH_DEFAULT = 8;
    // cs polarity is shared with the receive end of the link
    localparam logic CS_ASSERT         = 1'b0;
    localparam logic CS_DEASSERT       = 1'b1;
endpackage

// File: rtl/spi_transmit_if.sv
// rtl/spi_transmit_if.sv - producer-side word handshake into spi_transmit
interface spi_transmit_if import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - small synchronous FIFO decoupling the word producer from line timing
module spi_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/spi_transmit.sv
// rtl/spi_transmit.sv - serialises FIFO-buffered words onto a cs-framed sdo line
module spi_transmit import spi_pkg::*; #(
    parameter int WIDTH     = SPI_WIDTH_DEFAULT,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int BURST     = 1,
    parameter int CS_GAP    = 2
) (
    input  logic           clk,
    input  logic           nrst,
    spi_transmit_if.slave  in_if,
    output logic           cs,
    output logic           sdo,
    output logic           word_done,
    output logic           busy
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(CS_GAP + 1);

    spi_tx_state_t    state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0]    gapcnt_q, gapcnt_d;
    logic             cs_q, cs_d;
    logic             sdo_q, sdo_d;
    logic             word_done_q, word_done_d;
    logic             rst_done_q;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;

    // Held low through reset and released on the first edge afterwards.
    assign in_if.in_ready = rst_done_q && !fifo_full;

    spi_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (in_if.in_valid && in_if.in_ready),
        .wdata (in_if.in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        gapcnt_d    = gapcnt_q;
        cs_d        = cs_q;
        sdo_d       = sdo_q;
        word_done_d = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                cs_d  = CS_DEASSERT;
                sdo_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt_q == BW'(WIDTH - 1)) begin
                    word_done_d = 1'b1;
                    if ((BURST != 0) && !fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        cs_d     = CS_DEASSERT;
                        sdo_d    = 1'b0;
                        gapcnt_d = '0;
                        state_d  = GAP;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    sdo_d    = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
                    shift_d  = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                end
            end
            GAP: begin
                if (gapcnt_q == GW'(CS_GAP - 1)) state_d = IDLE;
                else                             gapcnt_d = gapcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Every pop starts a word: first bit goes out now, the rest wait in the shifter.
        if (fifo_pop) begin
            cs_d     = CS_ASSERT;
            bitcnt_d = '0;
            sdo_d    = (MSB_FIRST != 0) ? fifo_rdata[WIDTH-1] : fifo_rdata[0];
            shift_d  = (MSB_FIRST != 0) ? (fifo_rdata << 1) : (fifo_rdata >> 1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            cs_q        <= CS_DEASSERT;
            sdo_q       <= 1'b0;
            word_done_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            gapcnt_q    <= gapcnt_d;
            cs_q        <= cs_d;
            sdo_q       <= sdo_d;
            word_done_q <= word_done_d;
            rst_done_q  <= 1'b1;
        end
    end

    assign cs        = cs_q;
    assign sdo       = sdo_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_spi_transmit.sv
// tb/tb_spi_transmit.sv - scoreboard bench: burst (LSB-first) and framed (MSB-first) instances
module tb_spi_transmit;
    localparam int W      = 8;
    localparam int CS_GAP = 2;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [W-1:0] drv_data = '0;
    logic         drv_valid = 1'b0;
    int           sel = 0;

    always #5 clk = ~clk;

    spi_transmit_if #(.WIDTH(W)) if0 ();
    spi_transmit_if #(.WIDTH(W)) if1 ();
    assign if0.in_data  = drv_data;
    assign if1.in_data  = drv_data;
    assign if0.in_valid = drv_valid && (sel == 0);
    assign if1.in_valid = drv_valid && (sel == 1);

    logic cs0, sdo0, wd0, busy0;
    logic cs1, sdo1, wd1, busy1;

    spi_transmit #(.WIDTH(W), .DEPTH(4), .MSB_FIRST(0), .BURST(1), .CS_GAP(CS_GAP)) dut0 (
        .clk(clk), .nrst(nrst), .in_if(if0), .cs(cs0), .sdo(sdo0), .word_done(wd0), .busy(busy0));
    spi_transmit #(.WIDTH(W), .DEPTH(4), .MSB_FIRST(1), .BURST(0), .CS_GAP(CS_GAP)) dut1 (
        .clk(clk), .nrst(nrst), .in_if(if1), .cs(cs1), .sdo(sdo1), .word_done(wd1), .busy(busy1));

    wire cur_ready = (sel == 1) ? if1.in_ready : if0.in_ready;
    wire cur_busy  = (sel == 1) ? busy1 : busy0;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];

    // Receive-side model for the burst instance (LSB first)
    int           bit0 = 0, lo_run0 = 0, hi_run0 = 0, last_run0 = 0, words0 = 0, wdone0 = 0;
    logic         prev_cs0 = 1'b1, last0 = 1'b0, seen0 = 1'b0;
    logic [W-1:0] rx0;

    always @(negedge clk) begin
        logic nl;
        nl = 1'b0;
        check_eq("word_done0", wd0, last0);
        if (wd0) wdone0++;
        if (cs0 == 1'b0) begin
            if (prev_cs0 && seen0) check_eq("gap0", hi_run0 >= CS_GAP + 1, 1);
            hi_run0 = 0;
            lo_run0++;
            rx0[bit0] = sdo0;
            bit0++;
            if (bit0 == W) begin
                bit0 = 0;
                nl = 1'b1;
                words0++;
                if (exp0.size() == 0) check_eq("rx0_unexpected", 1, 0);
                else                  check_eq("rx0", rx0, exp0.pop_front());
            end
        end else begin
            if (!prev_cs0) begin
                last_run0 = lo_run0;
                seen0 = 1'b1;
            end
            check_eq("idle_sdo0", sdo0, 0);
            lo_run0 = 0;
            hi_run0++;
            bit0 = 0;
        end
        last0 = nl;
        prev_cs0 = cs0;
    end

    // Receive-side model for the one-word-per-frame instance (MSB first)
    int           bit1 = 0, lo_run1 = 0, hi_run1 = 0, frames1 = 0;
    logic         prev_cs1 = 1'b1, last1 = 1'b0, seen1 = 1'b0;
    logic [W-1:0] rx1;

    always @(negedge clk) begin
        logic nl;
        nl = 1'b0;
        check_eq("word_done1", wd1, last1);
        if (cs1 == 1'b0) begin
            if (prev_cs1 && seen1) check_eq("gap1", hi_run1 >= CS_GAP + 1, 1);
            hi_run1 = 0;
            lo_run1++;
            rx1[W-1-bit1] = sdo1;
            bit1++;
            if (bit1 == W) begin
                bit1 = 0;
                nl = 1'b1;
                if (exp1.size() == 0) check_eq("rx1_unexpected", 1, 0);
                else                  check_eq("rx1", rx1, exp1.pop_front());
            end
        end else begin
            if (!prev_cs1) begin
                check_eq("frame_len1", lo_run1, W);
                frames1++;
                seen1 = 1'b1;
            end
            check_eq("idle_sdo1", sdo1, 0);
            lo_run1 = 0;
            hi_run1++;
            bit1 = 0;
        end
        last1 = nl;
        prev_cs1 = cs1;
    end

    logic seen_full = 1'b0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer edge.
    task automatic push(input logic [W-1:0] d);
        int n;
        n = 0;
        drv_data  = d;
        drv_valid = 1'b1;
        while (!cur_ready && n < 200) begin
            step();
            n++;
        end
        if (n > 0) seen_full = 1'b1;
        if (n >= 200) begin
            check_eq("push_timeout", n, 0);
        end else begin
            if (sel == 1) exp1.push_back(d);
            else          exp0.push_back(d);
            step();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cur_busy && n < 1000) begin
            step();
            n++;
        end
        check_eq("idle_timeout", n < 1000, 1);
    endtask

    initial begin
        int n;
        int wd_before;

        // Reset with a word offered
        sel = 0;
        drv_valid = 1'b1;
        drv_data = 8'h55;
        nrst = 1'b0;
        repeat (3) step();
        check_eq("rst_cs", cs0, 1);
        check_eq("rst_sdo", sdo0, 0);
        check_eq("rst_ready", if0.in_ready, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_ready1", if1.in_ready, 0);
        nrst = 1'b1;
        step();
        check_eq("ready_after_rst", if0.in_ready, 1);
        drv_valid = 1'b0;
        step();
        check_eq("no_frame_cs", cs0, 1);
        check_eq("no_frame_busy", busy0, 0);

        // Single word, minimum latency, gap before idle
        push(8'b1001_1100);
        drv_valid = 1'b0;
        check_eq("lat_cs_high", cs0, 1);
        step();
        check_eq("lat_cs_low", cs0, 0);
        check_eq("lat_bit0", sdo0, 0);
        wait_idle();
        check_eq("single_len", last_run0, W);
        check_eq("single_gap_at_idle", hi_run0, CS_GAP + 1);

        // Back-to-back burst
        push(8'hA5);
        push(8'h3C);
        drv_valid = 1'b0;
        wait_idle();
        check_eq("burst_len", last_run0, 2 * W);
        check_eq("burst_gap_at_idle", hi_run0, CS_GAP + 1);

        // Backpressure: six words into a four-entry FIFO
        seen_full = 1'b0;
        for (int i = 0; i < 6; i++) push(W'($urandom));
        drv_valid = 1'b0;
        check_eq("backpressure_seen", seen_full, 1);
        wait_idle();
        check_eq("bp_len", last_run0, 6 * W);

        // Loopback-style sequence
        push(8'h00);
        push(8'hFF);
        push(8'h9C);
        drv_valid = 1'b0;
        wait_idle();
        check_eq("loop_len", last_run0, 3 * W);
        check_eq("we_per_word", wdone0, words0);

        // One word per frame, MSB first
        sel = 1;
        push(8'hA5);
        push(8'h3C);
        drv_valid = 1'b0;
        wait_idle();
        check_eq("frames1", frames1, 2);
        check_eq("gap1_at_idle", hi_run1, CS_GAP + 1);

        // Reset part-way through a word
        sel = 0;
        push(8'hFF);
        drv_valid = 1'b0;
        n = 0;
        while (cs0 && n < 50) begin
            step();
            n++;
        end
        check_eq("frame_start_timeout", n < 50, 1);
        repeat (3) step();
        wd_before = wdone0;
        #2 nrst = 1'b0;
        #1;
        check_eq("abort_cs", cs0, 1);
        check_eq("abort_wd", wd0, 0);
        check_eq("abort_ready", if0.in_ready, 0);
        check_eq("abort_busy", busy0, 0);
        exp0.delete();
        repeat (2) step();
        nrst = 1'b1;
        step();
        check_eq("post_abort_busy", busy0, 0);
        check_eq("post_abort_cs", cs0, 1);
        check_eq("post_abort_ready", if0.in_ready, 1);
        repeat (3) step();
        check_eq("abort_no_word_done", wdone0, wd_before);

        // Recovery after the abort
        push(8'h5A);
        drv_valid = 1'b0;
        wait_idle();
        check_eq("recover_len", last_run0, W);

        check_eq("exp0_drained", exp0.size(), 0);
        check_eq("exp1_drained", exp1.size(), 0);
        check_eq("we_total", wdone0, words0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
